pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Watches ID/EX pipeline-register contents and ID-stage operands, and drives write-enable, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles three cases: load-use hazards (1-cycle bubble), taken branches (IF/ID flush), and multi-cycle multiply/divide in EX (full front-end freeze with cycle counter).
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MD_LATENCY, 32, total EX cycles a mult/div occupies, including the start cycle; legal range 2..255.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- MemRead_EX  input  1  ID/EX instruction is a load.
- Rt_EX  input  5  load destination register in EX.
- Rs_ID  input  5  ID-stage source register rs.
- Rt_ID  input  5  ID-stage source register rt.
- UsesRt_ID  input  1  ID instruction reads rt as a source (R-type, store, branch).
- BranchTaken_ID  input  1  branch in ID resolved taken.
- MDStart_EX  input  1  EX instruction is mult/div; valid only in RUN.
- PCWrite  output  1  PC update enable.
- IFID_Write  output  1  IF/ID load enable.
- IFID_Flush  output  1  clear IF/ID to NOP on next edge.
- IDEX_Write  output  1  ID/EX load enable (0 = hold).
- IDEX_Bubble  output  1  load zero WB/MEM/EX control fields into ID/EX.
- EXMEM_Bubble  output  1  load zero control into EX/MEM.
- MDBusy  output  1  high while in MD_WAIT.
- MDDone  output  1  registered 1-cycle pulse the cycle after the final MD_WAIT cycle.
- StallCnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Async reset (Rst_n=0):
  - state=RUN, md_cnt=0, MDDone=0, StallCnt=0.
  - While Rst_n=0, all combinational outputs are forced to 0 (PCWrite, IFID_Write, IDEX_Write included).
- Load-use hazard term: lu = MemRead_EX & (Rt_EX!=0) & ((Rt_EX==Rs_ID) | (UsesRt_ID & Rt_EX==Rt_ID)).
- States: RUN, MD_WAIT.
- RUN, priority MDStart_EX > lu > BranchTaken_ID:
  - Default: PCWrite=1, IFID_Write=1, IDEX_Write=1, all bubbles/flushes 0.
  - MDStart_EX=1:
    - This cycle counts as EX cycle 1. Next state MD_WAIT, md_cnt <= MD_LATENCY-2.
    - Freeze this cycle: PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1.
    - lu and branch are ignored this cycle.
  - lu=1, no MDStart_EX: PCWrite=0, IFID_Write=0, IDEX_Bubble=1 (IDEX_Write stays 1). Exactly one bubble; the load advances to MEM, so lu clears next cycle.
  - BranchTaken_ID=1, no lu: IFID_Flush=1, PCWrite=1. If lu is also set, the stall wins and the branch is re-evaluated next cycle with forwarded data.
- MD_WAIT:
  - MDBusy=1. Freeze as for MDStart_EX (PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1).
  - lu, BranchTaken_ID and MDStart_EX are ignored.
  - md_cnt decrements each cycle. When md_cnt==0 this is the final frozen cycle: next state RUN and MDDone<=1.
  - Total frozen cycles = MD_LATENCY, including the start cycle.
- MDDone is registered: high for exactly the first RUN cycle after MD_WAIT, 0 otherwise.
- StallCnt:
  - Increments on every edge where PCWrite=0 and Rst_n=1.
  - Saturates at 2^CNT_W-1 (no wrap).
- Reset mid-MD_WAIT aborts the operation immediately: no MDDone pulse, state=RUN.
- Rt_EX==0 never causes a stall, whatever MemRead_EX is.

Test Plan:
- Reset: Rst_n=0 asserted between clock edges -> StallCnt=0, MDBusy=0 and all enables 0 immediately; after release with no hazards -> PCWrite=IFID_Write=IDEX_Write=1.
- Load-use: MemRead_EX=1, Rt_EX=8, Rs_ID=8 -> exactly one cycle of PCWrite=0, IFID_Write=0, IDEX_Bubble=1; StallCnt 0->1. Repeat with Rt_EX=0 -> no stall.
- Rt-only dependency: Rt_EX=5, Rt_ID=5, Rs_ID=3 -> stall when UsesRt_ID=1, no stall when UsesRt_ID=0.
- Branch vs load-use: BranchTaken_ID=1 with lu=1 -> no IFID_Flush, stall taken; next cycle with lu=0 -> IFID_Flush=1, PCWrite=1.
- Mult/div, MD_LATENCY=4: MDStart_EX pulse -> PCWrite=0 for exactly 4 cycles, MDBusy high 3 cycles, MDDone high on cycle 5; BranchTaken_ID pulsed mid-wait -> ignored; StallCnt +=4.
- Abort and saturation: Rst_n pulsed low during MD_WAIT -> state RUN, no MDDone. With CNT_W=4, hold lu for 20 cycles -> StallCnt stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// IF/ID flushes, and a full front-end freeze while a multi-cycle mult/div occupies EX.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rt_EX,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UsesRt_ID,
  input  logic             BranchTaken_ID,
  input  logic             MDStart_EX,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Bubble,
  output logic             MDBusy,
  output logic             MDDone,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t     state;
  logic [7:0] md_cnt;
  logic       lu;
  logic       freeze;

  // r0 is hardwired zero, so a load targeting it can never create a dependency.
  assign lu = MemRead_EX & (Rt_EX != 5'd0) &
              ((Rt_EX == Rs_ID) | (UsesRt_ID & (Rt_EX == Rt_ID)));

  assign freeze = (state == MD_WAIT) | MDStart_EX;

  // Controls are held inactive during reset so nothing in the pipe moves.
  always_comb begin
    PCWrite      = 1'b0;
    IFID_Write   = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    MDBusy       = 1'b0;
    if (Rst_n) begin
      PCWrite    = 1'b1;
      IFID_Write = 1'b1;
      IDEX_Write = 1'b1;
      if (freeze) begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
        MDBusy       = (state == MD_WAIT);
      end else if (lu) begin
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end else if (BranchTaken_ID) begin
        IFID_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= RUN;
      md_cnt   <= 8'd0;
      MDDone   <= 1'b0;
      StallCnt <= '0;
    end else begin
      MDDone <= 1'b0;
      case (state)
        RUN: begin
          if (MDStart_EX) begin
            state  <= MD_WAIT;
            md_cnt <= 8'(MD_LATENCY - 2);
          end
        end
        MD_WAIT: begin
          if (md_cnt == 8'd0) begin
            state  <= RUN;
            MDDone <= 1'b1;
          end else begin
            md_cnt <= md_cnt - 8'd1;
          end
        end
        default: state <= RUN;
      endcase
      if (!PCWrite && (StallCnt != {CNT_W{1'b1}}))
        StallCnt <= StallCnt + 1'b1;
    end
  end

endmodule
